// File: rtl/sigma_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : sigma_sequencer (+ right_rotator)
//  Brief    : SHA-256 Sigma/sigma evaluator sharing one rotator over 3 cycles.
//  Revision : 1.0 - initial release
// ============================================================================

module right_rotator (
   input  logic [31:0] data_in,
   input  logic [4:0]  rotate_amt,
   output logic [31:0] data_out
);

   // Output bit i takes input bit (i + amt) mod 32; the 5-bit index wraps naturally.
   always_comb begin
      data_out = '0;
      for (int i = 0; i < 32; i++) begin
         data_out[i] = data_in[5'(i) + rotate_amt];
      end
   end

endmodule

module sigma_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_word,
   input  logic [1:0]  func_sel,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_word,
   output logic        busy,
   output logic [7:0]  op_count
);

   localparam logic [2:0] c_st_idle = 3'd0;
   localparam logic [2:0] c_st_rot0 = 3'd1;
   localparam logic [2:0] c_st_rot1 = 3'd2;
   localparam logic [2:0] c_st_rot2 = 3'd3;
   localparam logic [2:0] c_st_done = 3'd4;

   localparam logic [1:0] c_fn_big_s0   = 2'd0;
   localparam logic [1:0] c_fn_big_s1   = 2'd1;
   localparam logic [1:0] c_fn_small_s0 = 2'd2;
   localparam logic [1:0] c_fn_small_s1 = 2'd3;

   logic [2:0]  r_state;
   logic [2:0]  w_next_state;
   logic [31:0] r_acc;
   logic [31:0] r_word;
   logic [1:0]  r_func;
   logic [7:0]  r_op_count;

   logic [4:0]  w_amt_a;
   logic [4:0]  w_amt_b;
   logic [4:0]  w_amt_c;
   logic [4:0]  w_rot_amt;
   logic [31:0] w_rot_out;
   logic [31:0] w_shr_mask;
   logic [31:0] w_term;
   logic        w_accept;
   logic        w_retire;

   // ------------------------------------------------------------------
   // Rotate amounts for the three terms of the selected function
   // ------------------------------------------------------------------
   always_comb begin
      w_amt_a = 5'd0;
      w_amt_b = 5'd0;
      w_amt_c = 5'd0;
      case (r_func)
         c_fn_big_s0: begin
            w_amt_a = 5'd2;
            w_amt_b = 5'd13;
            w_amt_c = 5'd22;
         end
         c_fn_big_s1: begin
            w_amt_a = 5'd6;
            w_amt_b = 5'd11;
            w_amt_c = 5'd25;
         end
         c_fn_small_s0: begin
            w_amt_a = 5'd7;
            w_amt_b = 5'd18;
            w_amt_c = 5'd3;
         end
         c_fn_small_s1: begin
            w_amt_a = 5'd17;
            w_amt_b = 5'd19;
            w_amt_c = 5'd10;
         end
         default: begin
            w_amt_a = 5'd0;
            w_amt_b = 5'd0;
            w_amt_c = 5'd0;
         end
      endcase
   end

   always_comb begin
      w_rot_amt = 5'd0;
      case (r_state)
         c_st_rot0: w_rot_amt = w_amt_a;
         c_st_rot1: w_rot_amt = w_amt_b;
         c_st_rot2: w_rot_amt = w_amt_c;
         default:   w_rot_amt = 5'd0;
      endcase
   end

   right_rotator u_rotator (
      .data_in    (r_word),
      .rotate_amt (w_rot_amt),
      .data_out   (w_rot_out)
   );

   // A logical shift right by n is the rotation with the wrapped top n bits cleared.
   assign w_shr_mask = 32'hFFFF_FFFF >> w_rot_amt;

   always_comb begin
      w_term = w_rot_out;
      if ((r_state == c_st_rot2) && r_func[1]) begin
         w_term = w_rot_out & w_shr_mask;
      end
   end

   assign w_accept = (r_state == c_st_idle) && in_valid;
   assign w_retire = (r_state == c_st_done) && out_ready;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_st_idle: if (in_valid) w_next_state = c_st_rot0;
         c_st_rot0: w_next_state = c_st_rot1;
         c_st_rot1: w_next_state = c_st_rot2;
         c_st_rot2: w_next_state = c_st_done;
         c_st_done: if (out_ready) w_next_state = c_st_idle;
         default:   w_next_state = c_st_idle;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_word  = 32'd0;
      busy      = 1'b1;
      case (r_state)
         c_st_idle: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         c_st_done: begin
            out_valid = 1'b1;
            out_word  = r_acc;
         end
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   assign op_count = r_op_count;

   // ------------------------------------------------------------------
   // Datapath: operand capture, accumulation and job counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_word     <= 32'd0;
         r_func     <= 2'd0;
         r_acc      <= 32'd0;
         r_op_count <= 8'd0;
      end else begin
         if (w_accept) begin
            r_word <= in_word;
            r_func <= func_sel;
         end
         case (r_state)
            c_st_rot0: r_acc <= w_term;
            c_st_rot1: r_acc <= r_acc ^ w_term;
            c_st_rot2: r_acc <= r_acc ^ w_term;
            default:   r_acc <= r_acc;
         endcase
         if (w_retire) begin
            r_op_count <= r_op_count + 8'd1;
         end
      end
   end

endmodule

`default_nettype wire
